// File: rtl/sort_checker.sv
// Avalon-ST sink that checks sorted packets for ordering, framing and length,
// and reports per-packet results with a done pulse and running counters.
module sort_checker #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 1024,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned LEN_W      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  pkt_len_o,
  output logic [DWIDTH-1:0] min_o,
  output logic [DWIDTH-1:0] max_o,
  output logic              err_order_o,
  output logic              err_frame_o,
  output logic              err_len_o,
  output logic              stray_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  // One spare bit keeps the saturation value representable for any MAX_PKT_LEN.
  localparam int unsigned      LenIW  = LEN_W + 1;
  localparam logic [LenIW-1:0] LenSat = LenIW'(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StReport} state_e;

  state_e            state_q, state_d;
  logic [LenIW-1:0]  len_q, len_d;
  logic [DWIDTH-1:0] last_q, last_d;
  logic [DWIDTH-1:0] min_q, min_d;
  logic [DWIDTH-1:0] max_q, max_d;
  logic              e_order_q, e_order_d;
  logic              e_frame_q, e_frame_d;
  logic              e_len_q, e_len_d;
  logic              stray_d;
  logic              report;
  logic              beat;

  assign beat = snk_valid_i && snk_ready_o;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    e_order_d = e_order_q;
    e_frame_d = e_frame_q;
    e_len_d   = e_len_q;
    stray_d   = 1'b0;
    report    = 1'b0;
    case (state_q)
      StIdle: begin
        if (beat) begin
          if (snk_startofpacket_i) begin
            len_d     = LenIW'(1);
            last_d    = snk_data_i;
            min_d     = snk_data_i;
            max_d     = snk_data_i;
            e_order_d = 1'b0;
            e_frame_d = 1'b0;
            e_len_d   = 1'b0;
            if (snk_endofpacket_i) begin
              state_d = StReport;
              report  = 1'b1;
            end else begin
              state_d = StRecv;
            end
          end else begin
            stray_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (beat) begin
          if (len_q != LenSat) len_d = len_q + LenIW'(1);
          if (len_d == LenSat) e_len_d = 1'b1;
          if (snk_data_i < last_q) e_order_d = 1'b1;
          if (snk_data_i < min_q) min_d = snk_data_i;
          if (snk_data_i > max_q) max_d = snk_data_i;
          last_d = snk_data_i;
          // A SOP inside a packet is flagged but the word still counts as data.
          if (snk_startofpacket_i) e_frame_d = 1'b1;
          if (snk_endofpacket_i) begin
            state_d = StReport;
            report  = 1'b1;
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      last_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      e_order_q   <= 1'b0;
      e_frame_q   <= 1'b0;
      e_len_q     <= 1'b0;
      snk_ready_o <= 1'b1;
      done_o      <= 1'b0;
      stray_o     <= 1'b0;
      pkt_len_o   <= '0;
      min_o       <= '0;
      max_o       <= '0;
      err_order_o <= 1'b0;
      err_frame_o <= 1'b0;
      err_len_o   <= 1'b0;
      pkt_cnt_o   <= '0;
      err_cnt_o   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      last_q      <= last_d;
      min_q       <= min_d;
      max_q       <= max_d;
      e_order_q   <= e_order_d;
      e_frame_q   <= e_frame_d;
      e_len_q     <= e_len_d;
      snk_ready_o <= (state_d != StReport);
      done_o      <= report;
      stray_o     <= stray_d;
      // Results load on the EOP edge so they are visible during the report cycle.
      if (report) begin
        pkt_len_o   <= len_d[LEN_W-1:0];
        min_o       <= min_d;
        max_o       <= max_d;
        err_order_o <= e_order_d;
        err_frame_o <= e_frame_d;
        err_len_o   <= e_len_d;
        pkt_cnt_o   <= pkt_cnt_o + CNT_W'(1);
        if (e_order_d || e_frame_d || e_len_d) err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sort_checker.sv
// Randomized bench for sort_checker: two instances (MAX_PKT_LEN 1024 and 4) share
// stimulus; a packet-level model feeds scoreboard queues checked by a monitor.
module tb_sort_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, sop, eop, valid;
  logic [7:0] data;

  logic        rdy0, done0, eo0, ef0, el0, stray0;
  logic [10:0] len0;
  logic [7:0]  mn0, mx0;
  logic [15:0] pc0, ec0;
  logic        rdy1, done1, eo1, ef1, el1, stray1;
  logic [2:0]  len1;
  logic [7:0]  mn1, mx1;
  logic [15:0] pc1, ec1;

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(1024), .CNT_W(16)) dut0 (
    .clk_i(clk), .srst_i(srst), .snk_data_i(data), .snk_startofpacket_i(sop),
    .snk_endofpacket_i(eop), .snk_valid_i(valid), .snk_ready_o(rdy0), .done_o(done0),
    .pkt_len_o(len0), .min_o(mn0), .max_o(mx0), .err_order_o(eo0), .err_frame_o(ef0),
    .err_len_o(el0), .stray_o(stray0), .pkt_cnt_o(pc0), .err_cnt_o(ec0)
  );

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(4), .CNT_W(16)) dut1 (
    .clk_i(clk), .srst_i(srst), .snk_data_i(data), .snk_startofpacket_i(sop),
    .snk_endofpacket_i(eop), .snk_valid_i(valid), .snk_ready_o(rdy1), .done_o(done1),
    .pkt_len_o(len1), .min_o(mn1), .max_o(mx1), .err_order_o(eo1), .err_frame_o(ef1),
    .err_len_o(el1), .stray_o(stray1), .pkt_cnt_o(pc1), .err_cnt_o(ec1)
  );

  typedef struct {
    int len; int mn; int mx; bit eo; bit ef; bit el; int pc; int ec;
  } rep_t;

  rep_t q0[$];
  rep_t q1[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  bit   exp_ready = 1'b1;
  bit   exp_done  = 1'b0;
  bit   exp_stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level reference model: collects whole packets and derives results.
  initial begin : model
    int  pkt[$];
    bit  in_pkt, in_rep, fe;
    int  pcnt;
    int  ecnt[2];
    int  maxs[2];
    int  n, mn, mx;
    bit  eo;
    rep_t r;
    maxs[0] = 1024; maxs[1] = 4;
    in_pkt = 0; in_rep = 0; fe = 0; pcnt = 0; ecnt[0] = 0; ecnt[1] = 0;
    forever begin
      @(posedge clk);
      exp_done  = 1'b0;
      exp_stray = 1'b0;
      if (srst) begin
        in_pkt = 0; in_rep = 0; pkt.delete(); pcnt = 0; ecnt[0] = 0; ecnt[1] = 0;
      end else if (in_rep) begin
        in_rep = 0;
      end else if (valid) begin
        if (!in_pkt) begin
          if (sop) begin
            pkt = {int'(data)}; fe = 0; in_pkt = 1;
          end else begin
            exp_stray = 1'b1;
          end
        end else begin
          pkt.push_back(int'(data));
          if (sop) fe = 1;
        end
        if (in_pkt && eop) begin
          n = pkt.size(); mn = pkt[0]; mx = pkt[0]; eo = 0;
          for (int i = 1; i < n; i++) begin
            if (pkt[i] < mn) mn = pkt[i];
            if (pkt[i] > mx) mx = pkt[i];
            if (pkt[i] < pkt[i-1]) eo = 1;
          end
          pcnt++;
          for (int k = 0; k < 2; k++) begin
            r.len = (n > maxs[k]) ? maxs[k] + 1 : n;
            r.el  = (n > maxs[k]);
            r.mn = mn; r.mx = mx; r.eo = eo; r.ef = fe;
            if (r.eo || r.ef || r.el) ecnt[k]++;
            r.pc = pcnt % 65536;
            r.ec = ecnt[k] % 65536;
            if (k == 0) q0.push_back(r); else q1.push_back(r);
          end
          in_pkt = 0; in_rep = 1; exp_done = 1'b1;
        end
      end
      exp_ready = !in_rep;
    end
  end

  initial begin : monitor
    rep_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ready0", rdy0, exp_ready);
      chk("ready1", rdy1, exp_ready);
      chk("done0", done0, exp_done);
      chk("done1", done1, exp_done);
      chk("stray0", stray0, exp_stray);
      chk("stray1", stray1, exp_stray);
      if (done0 && q0.size() > 0) begin
        r = q0.pop_front();
        chk("len0", len0, r.len); chk("min0", mn0, r.mn); chk("max0", mx0, r.mx);
        chk("eord0", eo0, r.eo);  chk("efrm0", ef0, r.ef); chk("elen0", el0, r.el);
        chk("pcnt0", pc0, r.pc);  chk("ecnt0", ec0, r.ec);
      end
      if (done1 && q1.size() > 0) begin
        r = q1.pop_front();
        chk("len1", len1, r.len); chk("min1", mn1, r.mn); chk("max1", mx1, r.mx);
        chk("eord1", eo1, r.eo);  chk("efrm1", ef1, r.ef); chk("elen1", el1, r.el);
        chk("pcnt1", pc1, r.pc);  chk("ecnt1", ec1, r.ec);
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic v);
    data = d; sop = s; eop = e; valid = v;
    @(posedge clk);
    #1;
  endtask

  // Sends one packet, then one cycle of random (ignored) traffic during the report cycle.
  task automatic send_pkt(input int w[$], input int sop_at, input bit gaps);
    for (int i = 0; i < w.size(); i++) begin
      if (gaps && i > 0)
        repeat ($urandom_range(0, 2)) drive(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      drive(8'(w[i]), (i == 0) || (i == sop_at), i == w.size() - 1, 1'b1);
    end
    drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin : stim
    int w[$];
    int n, sop_at;
    srst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_len", len0, 0);  chk("rst_min", mn0, 0);  chk("rst_max", mx0, 0);
    chk("rst_eo", eo0, 0);    chk("rst_ef", ef0, 0);   chk("rst_el", el0, 0);
    chk("rst_pc", pc0, 0);    chk("rst_ec", ec0, 0);   chk("rst_rdy", rdy0, 1);
    @(posedge clk);
    #1;
    srst = 1'b0;

    w = {1, 2, 2, 5, 9};
    send_pkt(w, -1, 1'b0);
    chk("t1_len", len0, 5); chk("t1_min", mn0, 1); chk("t1_max", mx0, 9);
    chk("t1_pc", pc0, 1);   chk("t1_ec", ec0, 0);

    w = {3, 7, 4, 8};
    send_pkt(w, -1, 1'b0);
    chk("t2_eo", eo0, 1); chk("t2_len", len0, 4); chk("t2_ec", ec0, 1);

    drive(8'h55, 1'b0, 1'b0, 1'b1);
    w = {170};
    send_pkt(w, -1, 1'b0);
    chk("t3_len", len0, 1); chk("t3_min", mn0, 8'hAA); chk("t3_pc", pc0, 3);

    w = {1, 2, 3, 4};
    send_pkt(w, 2, 1'b0);
    chk("t4_ef", ef0, 1); chk("t4_eo", eo0, 0); chk("t4_len", len0, 4);

    w = {10, 11, 12, 13, 14, 15};
    send_pkt(w, -1, 1'b1);
    chk("t5_len_big", len0, 6); chk("t5_len_small", len1, 5); chk("t5_el_small", el1, 1);

    drive(8'd20, 1'b1, 1'b0, 1'b1);
    drive(8'd21, 1'b0, 1'b0, 1'b1);
    drive(8'd22, 1'b0, 1'b0, 1'b1);
    srst = 1'b1;
    drive(8'd0, 1'b0, 1'b0, 1'b0);
    srst = 1'b0;
    w = {5, 6};
    send_pkt(w, -1, 1'b0);
    chk("t6_pc", pc0, 1); chk("t6_len", len0, 2); chk("t6_min", mn0, 5); chk("t6_max", mx0, 6);

    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 5) == 0) drive(8'($urandom), 1'b0, 1'($urandom), 1'b1);
      n = $urandom_range(1, 8);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) w.sort();
      sop_at = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
      send_pkt(w, sop_at, 1'($urandom));
    end

    repeat (3) drive(8'd0, 1'b0, 1'b0, 1'b0);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_checker.md
Name: sort_checker

Overview:
- Avalon-ST sink placed directly downstream of the packet sorter; consumes each sorted packet and checks it.
- Checks each packet for non-decreasing data order, correct SOP/EOP framing and length within MAX_PKT_LEN.
- Reports per-packet results (length, min, max, error flags) with a one-cycle done pulse, and keeps running packet and error counters.
- Used as the self-check stage in sorter benches and on-chip loopback.

Parameters:
DWIDTH, 8, data word width (matches the sorter).
MAX_PKT_LEN, 1024, longest legal packet in words.
CNT_W, 16, width of the packet and error counters.

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
snk_data_i  in  DWIDTH  input data word
snk_startofpacket_i  in  1  first word of packet
snk_endofpacket_i  in  1  last word of packet
snk_valid_i  in  1  input word valid
snk_ready_o  out  1  block can accept a word
done_o  out  1  one-cycle pulse: results valid
pkt_len_o  out  LEN_W  length of last packet, LEN_W = $clog2(MAX_PKT_LEN+1)
min_o  out  DWIDTH  smallest word of last packet
max_o  out  DWIDTH  largest word of last packet
err_order_o  out  1  last packet had a word smaller than the word before it
err_frame_o  out  1  last packet had a SOP inside the packet
err_len_o  out  1  last packet was longer than MAX_PKT_LEN
stray_o  out  1  one-cycle pulse: a word outside any packet was dropped
pkt_cnt_o  out  CNT_W  packets reported, wraps
err_cnt_o  out  CNT_W  reported packets with any error flag, wraps

Behaviour:
- Clock and reset: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Beat: a word transfers when snk_valid_i && snk_ready_o.
- All outputs are registered.
- Reset: state IDLE. All outputs are 0, except snk_ready_o = 1. Internal len, last, min and max are cleared.
- Reset mid-packet drops the partial packet; nothing is reported for it.
- States: IDLE, RECV, REPORT.
- IDLE, snk_ready_o = 1:
  - Beat without SOP: word dropped, stray_o pulses on the next cycle, stay in IDLE.
  - Beat with SOP: len = 1, min = max = last = data, packet error flags cleared.
  - SOP beat without EOP goes to RECV.
  - SOP+EOP in the same beat is a single-word packet and goes to REPORT.
- RECV, snk_ready_o = 1, on each beat:
  - len increments and saturates at MAX_PKT_LEN+1; reaching MAX_PKT_LEN+1 sets err_len.
  - data < last (unsigned) sets err_order.
  - min and max are updated (unsigned), and last = data.
  - SOP on this beat sets err_frame; the word is still counted as data and no restart happens.
  - EOP on this beat goes to REPORT.
  - Cycles with valid = 0 are idle; counters hold.
- REPORT, snk_ready_o = 0, lasts exactly 1 cycle:
  - done_o = 1 and pkt_len_o, min_o, max_o and the err_* outputs load the packet results.
  - pkt_cnt_o increments; err_cnt_o increments if any error flag is set.
  - Next state is IDLE.
- Latency: done_o rises exactly 1 cycle after the clock edge of the EOP beat. snk_ready_o is low for that one cycle only.
- Result outputs hold their value until the next REPORT. done_o and stray_o are high for one cycle only.
- Error flags are sticky within a packet and cleared at the next SOP accepted in IDLE.
- Throughput: a new SOP may be accepted in the cycle after REPORT, so there is 1 bubble per packet.
- Equal adjacent words are legal and do not set err_order.
- Counters wrap modulo 2^CNT_W; no saturation.
- pkt_len_o saturates at MAX_PKT_LEN+1 even if more words arrive before EOP.
- snk_valid_i during REPORT is ignored, because snk_ready_o = 0.

Test Plan:
- Reset, then packet 1,2,2,5,9 (SOP on 1, EOP on 9, valid every cycle) -> done_o one cycle after the 9 beat; pkt_len_o=5, min_o=1, max_o=9, all err_* = 0, pkt_cnt_o=1, err_cnt_o=0, snk_ready_o low only in the done cycle.
- Packet 3,7,4,8 -> err_order_o=1, pkt_len_o=4, min_o=3, max_o=8, err_cnt_o increments by 1.
- Single word 0xAA with SOP+EOP together -> pkt_len_o=1, min_o=max_o=0xAA, no errors; a word without SOP sent before it -> stray_o pulse and no report for that word.
- SOP re-asserted on the 3rd word of a 4-word ascending packet -> err_frame_o=1, pkt_len_o=4, err_order_o=0.
- MAX_PKT_LEN=4 build, 6 ascending words then EOP -> err_len_o=1, pkt_len_o=5; valid gaps inserted mid-packet change no results.
- srst_i asserted after 3 words of a packet, then a clean 2-word packet 5,6 -> exactly one done with pkt_len_o=2, min_o=5, max_o=6, pkt_cnt_o=1.
